// File: rtl/shared_reg_pkg.sv
// ============================================================================
// shared_reg_pkg : FSM state encoding and one-hot helper for shared_reg_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package shared_reg_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Bits at or above n stay clear so callers can truncate to their own width.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx, input int unsigned n);
    onehot = '0;
    if (idx < n) onehot = MAX_REQ'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shared_reg_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational winner selection (round-robin from rr_ptr, or
//           lowest-index priority when SHARED_REG_FIXED_PRIO_EN is defined)
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] win,
  output logic             found
);

`ifdef SHARED_REG_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^rr_ptr;

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        win   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int off = 0; off < N_REQ; off++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/shared_reg_arbiter.sv
// ============================================================================
// shared_reg_arbiter : four-phase req/gnt arbiter writing one shared register.
//                      Define SHARED_REG_FIXED_PRIO_EN for fixed priority.
// Revision 1.0
// ============================================================================
`default_nettype none

module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   q_upd,
  output logic                   busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state, state_d;
  logic [IDX_W-1:0] sel, sel_d;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win;
  logic             found;
  logic [N_REQ-1:0] gnt_d;
  logic [WIDTH-1:0] q_d;
  logic             q_upd_d;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .win    (win),
    .found  (found)
  );

`ifdef SHARED_REG_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (state == IDLE && found) begin
      rr_ptr <= (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      gnt   <= '0;
      q     <= '0;
      q_upd <= 1'b0;
    end else begin
      state <= state_d;
      sel   <= sel_d;
      gnt   <= gnt_d;
      q     <= q_d;
      q_upd <= q_upd_d;
    end
  end

  always_comb begin
    state_d = state;
    sel_d   = sel;
    gnt_d   = gnt;
    q_d     = q;
    q_upd_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = win;
          gnt_d   = N_REQ'(onehot(32'(win), N_REQ));
          q_d     = wdata[win*WIDTH +: WIDTH];
          q_upd_d = 1'b1;
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          gnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_shared_reg_arbiter.sv
// ============================================================================
// tb_shared_reg_arbiter : directed self-checking bench for shared_reg_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_shared_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N*W-1:0] wdata;
  logic [N-1:0] gnt;
  logic [W-1:0] q;
  logic         q_upd;
  logic         busy;

  int total = 0;
  int bad   = 0;

  shared_reg_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .q     (q),
    .q_upd (q_upd),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int order [5];
  int w1, w2;
  logic [7:0] d1, d2;

  initial begin
`ifdef SHARED_REG_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0};
    w1 = 0; d1 = 8'h11;
    w2 = 3; d2 = 8'h77;
`else
    order = '{0, 1, 2, 3, 0};
    w1 = 3; d1 = 8'h77;
    w2 = 0; d2 = 8'h11;
`endif
    rst   = 1'b1;
    req   = '0;
    wdata = '0;
    step();
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_q", q, 0);
    chk("rst_upd", q_upd, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Single requester
    wdata[2*W +: W] = 8'h3C;
    req = 4'b0100;
    step();
    chk("single_gnt", gnt, 4'b0100);
    chk("single_q", q, 8'h3C);
    chk("single_upd", q_upd, 1);
    chk("single_busy", busy, 1);
    step();
    chk("single_upd_off", q_upd, 0);
    chk("single_hold", gnt, 4'b0100);
    req = '0;
    step();
    chk("single_rel_gnt", gnt, 0);
    chk("single_gap_busy", busy, 1);
    step();
    chk("single_idle_busy", busy, 0);

    // Wrap: rr_ptr is 3 here
    wdata[3*W +: W] = 8'h77;
    wdata[0*W +: W] = 8'h11;
    req = 4'b1001;
    step();
    chk("wrap1_gnt", gnt, 1 << w1);
    chk("wrap1_q", q, d1);
    req[w1] = 1'b0;
    step();
    chk("wrap_gap_gnt", gnt, 0);
    step();
    chk("wrap_idle_gnt", gnt, 0);
    step();
    chk("wrap2_gnt", gnt, 1 << w2);
    chk("wrap2_q", q, d2);
    chk("wrap2_upd", q_upd, 1);
    req = '0;
    step();
    step();

    // Withdrawal of requester 1 while 0 holds the grant
    wdata[0*W +: W] = 8'h5A;
    wdata[1*W +: W] = 8'h99;
    req = 4'b0001;
    step();
    chk("wd_gnt0", gnt, 4'b0001);
    chk("wd_q0", q, 8'h5A);
    req = 4'b0011;
    step();
    chk("wd_pulse_gnt", gnt, 4'b0001);
    req = 4'b0001;
    step();
    chk("wd_keep_q", q, 8'h5A);
    req = '0;
    step();
    step();
    step();
    chk("wd_no_gnt1", gnt, 0);
    chk("wd_q_unch", q, 8'h5A);
    chk("wd_upd", q_upd, 0);

    // Hold: requester 3 keeps its grant while others queue up
    wdata[3*W +: W] = 8'hC3;
    req = 4'b1000;
    step();
    chk("hold_gnt", gnt, 4'b1000);
    chk("hold_q", q, 8'hC3);
    wdata[0*W +: W] = 8'hEE;
    wdata[1*W +: W] = 8'hEE;
    wdata[2*W +: W] = 8'hEE;
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_loop_gnt", gnt, 4'b1000);
      chk("hold_loop_q", q, 8'hC3);
    end
    req = '0;
    step();
    chk("hold_rel", gnt, 0);
    step();

    // Contention: all four held, each drops on grant and re-raises in GAP
    for (int i = 0; i < N; i++) wdata[i*W +: W] = 8'h10 + 8'(i);
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      step();
      chk("cont_gnt", gnt, 1 << order[r]);
      chk("cont_q", q, 8'h10 + order[r]);
      chk("cont_upd", q_upd, 1);
      req[order[r]] = 1'b0;
      step();
      chk("cont_gap_gnt", gnt, 0);
      chk("cont_gap_busy", busy, 1);
      req[order[r]] = 1'b1;
      step();
      chk("cont_idle_busy", busy, 0);
    end
    req = '0;
    step();
    step();

    // Asynchronous reset in the middle of a grant
    wdata[2*W +: W] = 8'hA5;
    req = 4'b0100;
    step();
    chk("mid_gnt", gnt, 4'b0100);
    chk("mid_q", q, 8'hA5);
    rst = 1'b1;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_q", q, 0);
    chk("arst_upd", q_upd, 0);
    chk("arst_busy", busy, 0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_gnt", gnt, 0);
    step();
    chk("post_rst_arb_gnt", gnt, 4'b0100);
    chk("post_rst_arb_q", q, 8'hA5);
    chk("post_rst_arb_upd", q_upd, 1);
    req = '0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
